// File: rtl/tri_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Package : tri_fetch_pkg
// Brief   : Shared graphics types for the triangle fetch front end.
// Rev     : 1.0 - initial release
// ============================================================================
package tri_fetch_pkg;

    localparam int VERTS_PER_TRI = 3;
    localparam int P_WIDTH_DEF   = 16;
    localparam int NUM_TRI_DEF   = 2048;
    localparam int TID_W_DEF     = $clog2(NUM_TRI_DEF);

    typedef logic signed [P_WIDTH_DEF-1:0] coord_t;

    // Memory word layout: x occupies the least-significant field
    typedef struct packed {
        coord_t z;
        coord_t y;
        coord_t x;
    } vertex_t;

    typedef logic [TID_W_DEF-1:0] tri_id_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic       valid;
        logic [1:0] k;
    } rd_tag_t;

endpackage
`default_nettype wire

// File: rtl/mem_read_tag_pipe.sv
`default_nettype none
// ============================================================================
// Module : mem_read_tag_pipe
// Brief  : DEPTH-stage shift register that tracks which vertex slot each
//          outstanding memory read belongs to.
// Rev    : 1.0 - initial release
// ============================================================================
module mem_read_tag_pipe
    import tri_fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic    clk_in,
    input  logic    rst_in,
    input  rd_tag_t tag_in,
    output rd_tag_t tag_out
);

    rd_tag_t [DEPTH-1:0] pipe_q;
    rd_tag_t [DEPTH-1:0] pipe_d;

    always_comb begin
        pipe_d    = '0;
        pipe_d[0] = tag_in;
        for (int i = 1; i < DEPTH; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign tag_out = pipe_q[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/tri_fetch.sv
`default_nettype none
// ============================================================================
// Module : tri_fetch
// Brief  : Walks a frame's triangles, reads three vertex words per triangle
//          and presents them with valid/ready, one triangle in flight.
// Rev    : 1.0 - initial release
// ============================================================================
module tri_fetch
    import tri_fetch_pkg::*;
#(
    parameter  int P_WIDTH     = 16,
    parameter  int NUM_TRI     = 2048,
    parameter  int MEM_LATENCY = 2,
    localparam int TID_W       = $clog2(NUM_TRI),
    parameter  int ADDR_W      = $clog2(3 * NUM_TRI)
) (
    input  logic                            clk_in,
    input  logic                            rst_in,
    input  logic                            start_in,
    input  logic [TID_W:0]                  tri_count_in,
    output logic                            rd_en_out,
    output logic [ADDR_W-1:0]               addr_out,
    input  logic [3*P_WIDTH-1:0]            rd_data_in,
    input  logic                            ready_in,
    output logic                            valid_out,
    output logic [TID_W-1:0]                tri_id_out,
    output logic [2:0][2:0][P_WIDTH-1:0]    P_out,
    output logic                            busy_out,
    output logic                            frame_done_out
);

    localparam logic [TID_W:0] MAX_COUNT = (TID_W+1)'(NUM_TRI);

    fetch_state_t                   state_q,  state_d;
    logic [TID_W:0]                 count_q,  count_d;
    logic [TID_W-1:0]               id_q,     id_d;
    logic [ADDR_W-1:0]              base_q,   base_d;
    logic [1:0]                     issue_k_q, issue_k_d;
    logic                           valid_q,  valid_d;
    logic [TID_W-1:0]               tri_id_q, tri_id_d;
    logic [2:0][2:0][P_WIDTH-1:0]   p_q,      p_d;
    logic                           done_q,   done_d;

    logic           w_issue;
    logic           w_last;
    logic [TID_W:0] w_count_clamped;
    rd_tag_t        w_tag_issue;
    rd_tag_t        w_tag_ret;

    assign w_issue = (state_q == ST_FETCH) && (issue_k_q != 2'(VERTS_PER_TRI));
    assign w_last  = ({1'b0, id_q} + (TID_W+1)'(1)) == count_q;
    assign w_count_clamped = (tri_count_in > MAX_COUNT) ? MAX_COUNT : tri_count_in;

    assign w_tag_issue.valid = w_issue;
    assign w_tag_issue.k     = issue_k_q;

    // Tags leave the pipe in the same cycle the matching read data arrives
    mem_read_tag_pipe #(
        .DEPTH (MEM_LATENCY)
    ) u_tag_pipe (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .tag_in  (w_tag_issue),
        .tag_out (w_tag_ret)
    );

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        id_d      = id_q;
        base_d    = base_q;
        issue_k_d = issue_k_q;
        valid_d   = valid_q;
        tri_id_d  = tri_id_q;
        p_d       = p_q;
        done_d    = 1'b0;

        if (w_tag_ret.valid) begin
            p_d[w_tag_ret.k] = rd_data_in;
        end

        case (state_q)
            ST_IDLE: begin
                if (start_in) begin
                    count_d = w_count_clamped;
                    if (w_count_clamped == '0) begin
                        done_d = 1'b1;
                    end else begin
                        id_d      = '0;
                        base_d    = '0;
                        issue_k_d = '0;
                        state_d   = ST_FETCH;
                    end
                end
            end
            ST_FETCH: begin
                if (w_issue) begin
                    issue_k_d = issue_k_q + 2'd1;
                end
                if (w_tag_ret.valid && (w_tag_ret.k == 2'd2)) begin
                    valid_d  = 1'b1;
                    tri_id_d = id_q;
                    state_d  = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (ready_in) begin
                    valid_d = 1'b0;
                    if (w_last) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        id_d      = id_q + 1'b1;
                        base_d    = base_q + ADDR_W'(VERTS_PER_TRI);
                        issue_k_d = '0;
                        state_d   = ST_FETCH;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            id_q      <= '0;
            base_q    <= '0;
            issue_k_q <= '0;
            valid_q   <= 1'b0;
            tri_id_q  <= '0;
            p_q       <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            id_q      <= id_d;
            base_q    <= base_d;
            issue_k_q <= issue_k_d;
            valid_q   <= valid_d;
            tri_id_q  <= tri_id_d;
            p_q       <= p_d;
            done_q    <= done_d;
        end
    end

    assign rd_en_out      = w_issue;
    assign addr_out       = base_q + ADDR_W'(issue_k_q);
    assign valid_out      = valid_q;
    assign tri_id_out     = tri_id_q;
    assign P_out          = p_q;
    assign busy_out       = (state_q != ST_IDLE);
    assign frame_done_out = done_q;

endmodule
`default_nettype wire

// File: tb/tb_tri_fetch.sv
`default_nettype none
// ============================================================================
// Module : tb_tri_fetch
// Brief  : Directed bench for tri_fetch at memory latencies 2 and 4.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_tri_fetch;

    logic clk;
    logic [1:0]       rst_r;
    logic [1:0]       start_r;
    logic [1:0]       ready_r;
    logic [1:0][11:0] cnt_r;

    wire [1:0]                  rd_en_w;
    wire [1:0][12:0]            addr_w;
    wire [1:0]                  valid_w;
    wire [1:0][10:0]            tid_w;
    wire [1:0][2:0][2:0][15:0]  p_w;
    wire [1:0]                  busy_w;
    wire [1:0]                  done_w;

    logic [47:0] mp0 [2];
    logic [47:0] mp1 [4];

    int total = 0;
    int bad   = 0;

    bit m_act  [2];
    bit m_hold [2];
    bit m_done [2];
    int m_id   [2];
    int m_cnt  [2];
    int m_age  [2];
    bit e_rd;
    bit nd;
    int done_cnt [2];
    int addr_q0 [$];
    int hs_q0 [$];
    int hs_q1 [$];

    tri_fetch #(.MEM_LATENCY(2)) u_dut0 (
        .clk_in(clk), .rst_in(rst_r[0]), .start_in(start_r[0]), .tri_count_in(cnt_r[0]),
        .rd_en_out(rd_en_w[0]), .addr_out(addr_w[0]), .rd_data_in(mp0[1]),
        .ready_in(ready_r[0]), .valid_out(valid_w[0]), .tri_id_out(tid_w[0]),
        .P_out(p_w[0]), .busy_out(busy_w[0]), .frame_done_out(done_w[0]));

    tri_fetch #(.MEM_LATENCY(4)) u_dut1 (
        .clk_in(clk), .rst_in(rst_r[1]), .start_in(start_r[1]), .tri_count_in(cnt_r[1]),
        .rd_en_out(rd_en_w[1]), .addr_out(addr_w[1]), .rd_data_in(mp1[3]),
        .ready_in(ready_r[1]), .valid_out(valid_w[1]), .tri_id_out(tid_w[1]),
        .P_out(p_w[1]), .busy_out(busy_w[1]), .frame_done_out(done_w[1]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Vertex memory contents: word a = {z,y,x} = {3a+3, 3a+2, 3a+1}
    function automatic logic [47:0] memw(input int a);
        logic [15:0] x, y, z;
        x = 16'(3 * a + 1);
        y = 16'(3 * a + 2);
        z = 16'(3 * a + 3);
        return {z, y, x};
    endfunction

    function automatic int lat(input int i);
        return (i == 0) ? 2 : 4;
    endfunction

    always @(posedge clk) begin
        mp0[0] <= memw(int'(addr_w[0]));
        mp0[1] <= mp0[0];
        mp1[0] <= memw(int'(addr_w[1]));
        for (int j = 1; j < 4; j++) mp1[j] <= mp1[j-1];
    end

    task automatic chk(input string name, input int inst, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s inst%0d got=%0h want=%0h t=%0t", name, inst, got, want, $time);
        end
    endtask

    // Per-cycle model check, then advance the model with the inputs the DUT samples next
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            e_rd = m_act[i] && !m_hold[i] && (m_age[i] < 3);
            chk("busy", i, 64'(busy_w[i]), 64'(m_act[i]));
            chk("rd_en", i, 64'(rd_en_w[i]), 64'(e_rd));
            if (e_rd) chk("addr", i, 64'(addr_w[i]), 64'(3 * m_id[i] + m_age[i]));
            chk("valid", i, 64'(valid_w[i]), 64'(m_hold[i]));
            chk("frame_done", i, 64'(done_w[i]), 64'(m_done[i]));
            if (m_hold[i]) begin
                chk("tri_id", i, 64'(tid_w[i]), 64'(m_id[i]));
                for (int k = 0; k < 3; k++)
                    chk("vertex", i, 64'(p_w[i][k]), 64'(memw(3 * m_id[i] + k)));
            end

            if (i == 0 && rd_en_w[0]) addr_q0.push_back(int'(addr_w[0]));
            if (valid_w[i] && ready_r[i] && !rst_r[i]) begin
                if (i == 0) hs_q0.push_back(int'(tid_w[0]));
                else        hs_q1.push_back(int'(tid_w[1]));
            end
            if (done_w[i]) done_cnt[i]++;

            if (rst_r[i]) begin
                m_act[i] = 1'b0; m_hold[i] = 1'b0; m_done[i] = 1'b0;
            end else begin
                nd = 1'b0;
                if (!m_act[i]) begin
                    if (start_r[i]) begin
                        m_cnt[i] = (int'(cnt_r[i]) > 2048) ? 2048 : int'(cnt_r[i]);
                        if (m_cnt[i] == 0) nd = 1'b1;
                        else begin
                            m_act[i] = 1'b1; m_id[i] = 0; m_age[i] = 0; m_hold[i] = 1'b0;
                        end
                    end
                end else if (!m_hold[i]) begin
                    m_age[i]++;
                    if (m_age[i] == 3 + lat(i)) m_hold[i] = 1'b1;
                end else if (ready_r[i]) begin
                    m_hold[i] = 1'b0;
                    if (m_id[i] == m_cnt[i] - 1) begin
                        m_act[i] = 1'b0; nd = 1'b1;
                    end else begin
                        m_id[i]++; m_age[i] = 0;
                    end
                end
                m_done[i] = nd;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input int i, input int c);
        cnt_r[i]   = 12'(c);
        start_r[i] = 1'b1;
        tick();
        start_r[i] = 1'b0;
    endtask

    task automatic wait_valid(input int i, input int max, output int n);
        n = 0;
        while (!valid_w[i] && n < max) begin
            tick();
            n++;
        end
        chk("valid_timeout", i, 64'(valid_w[i]), 64'd1);
    endtask

    task automatic wait_done(input int i, input int max);
        int n;
        n = 0;
        while (!done_w[i] && n < max) begin
            tick();
            n++;
        end
        chk("done_timeout", i, 64'(done_w[i]), 64'd1);
    endtask

    task automatic clear_logs();
        addr_q0.delete();
        hs_q0.delete();
        hs_q1.delete();
        done_cnt[0] = 0;
        done_cnt[1] = 0;
    endtask

    initial begin
        int n;
        rst_r = 2'b11; start_r = '0; ready_r = '0; cnt_r = '0;
        repeat (3) tick();
        rst_r = 2'b00;
        tick();

        // Reset state
        for (int i = 0; i < 2; i++) begin
            chk("rst_valid", i, 64'(valid_w[i]), 64'd0);
            chk("rst_busy", i, 64'(busy_w[i]), 64'd0);
            chk("rst_rd_en", i, 64'(rd_en_w[i]), 64'd0);
            chk("rst_addr", i, 64'(addr_w[i]), 64'd0);
            chk("rst_tid", i, 64'(tid_w[i]), 64'd0);
            chk("rst_p", i, 64'(p_w[i][0]) | 64'(p_w[i][1]) | 64'(p_w[i][2]), 64'd0);
        end

        // Single triangle
        ready_r[0] = 1'b1;
        clear_logs();
        start_frame(0, 1);
        wait_valid(0, 40, n);
        chk("lat_l2", 0, 64'(n), 64'd5);
        chk("t1_tid", 0, 64'(tid_w[0]), 64'd0);
        chk("t1_p00", 0, 64'(p_w[0][0][0]), 64'd1);
        chk("t1_p22", 0, 64'(p_w[0][2][2]), 64'd9);
        chk("t1_addr_cnt", 0, 64'(addr_q0.size()), 64'd3);
        for (int j = 0; j < addr_q0.size() && j < 3; j++)
            chk("t1_addr_seq", 0, 64'(addr_q0[j]), 64'(j));
        tick();
        chk("t1_done", 0, 64'(done_w[0]), 64'd1);
        chk("t1_valid_drop", 0, 64'(valid_w[0]), 64'd0);
        tick();
        chk("t1_done_end", 0, 64'(done_w[0]), 64'd0);

        // Backpressure
        ready_r[0] = 1'b0;
        clear_logs();
        start_frame(0, 2);
        wait_valid(0, 40, n);
        chk("bp_lat", 0, 64'(n), 64'd5);
        repeat (10) begin
            tick();
            chk("bp_valid", 0, 64'(valid_w[0]), 64'd1);
            chk("bp_tid", 0, 64'(tid_w[0]), 64'd0);
            chk("bp_p00", 0, 64'(p_w[0][0][0]), 64'd1);
            chk("bp_p22", 0, 64'(p_w[0][2][2]), 64'd9);
        end
        ready_r[0] = 1'b1;
        tick();
        chk("bp_valid_drop", 0, 64'(valid_w[0]), 64'd0);
        wait_valid(0, 40, n);
        chk("bp_lat2", 0, 64'(n), 64'd5);
        chk("bp_tid1", 0, 64'(tid_w[0]), 64'd1);
        chk("bp_p00_t1", 0, 64'(p_w[0][0][0]), 64'd10);
        chk("bp_p22_t1", 0, 64'(p_w[0][2][2]), 64'd18);
        chk("bp_addr_cnt", 0, 64'(addr_q0.size()), 64'd6);
        for (int j = 0; j < addr_q0.size() && j < 6; j++)
            chk("bp_addr_seq", 0, 64'(addr_q0[j]), 64'(j));
        tick();
        chk("bp_done", 0, 64'(done_w[0]), 64'd1);
        chk("bp_hs_cnt", 0, 64'(hs_q0.size()), 64'd2);
        tick();

        // Zero-count frame
        clear_logs();
        start_frame(0, 0);
        chk("z_done", 0, 64'(done_w[0]), 64'd1);
        chk("z_busy", 0, 64'(busy_w[0]), 64'd0);
        chk("z_rd_en", 0, 64'(rd_en_w[0]), 64'd0);
        chk("z_valid", 0, 64'(valid_w[0]), 64'd0);
        tick();
        chk("z_done_end", 0, 64'(done_w[0]), 64'd0);
        chk("z_busy2", 0, 64'(busy_w[0]), 64'd0);
        chk("z_addr_cnt", 0, 64'(addr_q0.size()), 64'd0);

        // start_in while holding
        ready_r[0] = 1'b0;
        clear_logs();
        start_frame(0, 2);
        wait_valid(0, 40, n);
        start_frame(0, 1);
        tick();
        chk("rs_tid", 0, 64'(tid_w[0]), 64'd0);
        chk("rs_valid", 0, 64'(valid_w[0]), 64'd1);
        ready_r[0] = 1'b1;
        wait_done(0, 60);
        repeat (3) tick();
        chk("rs_done_cnt", 0, 64'(done_cnt[0]), 64'd1);
        chk("rs_hs_cnt", 0, 64'(hs_q0.size()), 64'd2);
        for (int j = 0; j < hs_q0.size() && j < 2; j++)
            chk("rs_hs_seq", 0, 64'(hs_q0[j]), 64'(j));

        // Reset mid-fetch
        clear_logs();
        start_frame(0, 1);
        tick();
        rst_r[0] = 1'b1;
        tick();
        chk("mr_valid", 0, 64'(valid_w[0]), 64'd0);
        chk("mr_busy", 0, 64'(busy_w[0]), 64'd0);
        rst_r[0] = 1'b0;
        repeat (4) tick();
        chk("mr_no_done", 0, 64'(done_cnt[0]), 64'd0);
        for (int k = 0; k < 3; k++)
            chk("mr_p_clear", 0, 64'(p_w[0][k]), 64'd0);
        start_frame(0, 1);
        wait_valid(0, 40, n);
        chk("mr_lat", 0, 64'(n), 64'd5);
        chk("mr_p01", 0, 64'(p_w[0][0][1]), 64'd2);
        chk("mr_p12", 0, 64'(p_w[0][1][2]), 64'd6);
        tick();
        chk("mr_done", 0, 64'(done_w[0]), 64'd1);

        // Latency 4, three triangles, random consumer
        clear_logs();
        ready_r[1] = 1'b0;
        start_frame(1, 3);
        wait_valid(1, 60, n);
        chk("l4_lat", 1, 64'(n), 64'd7);
        n = 0;
        while (done_cnt[1] == 0 && n < 400) begin
            ready_r[1] = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        ready_r[1] = 1'b0;
        repeat (3) tick();
        chk("l4_done_cnt", 1, 64'(done_cnt[1]), 64'd1);
        chk("l4_hs_cnt", 1, 64'(hs_q1.size()), 64'd3);
        for (int j = 0; j < hs_q1.size() && j < 3; j++)
            chk("l4_hs_seq", 1, 64'(hs_q1[j]), 64'(j));

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        bad++;
        $display("FAIL watchdog expired t=%0t", $time);
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
